iic_slave_regs: RTL and testbench

//  IIC target (responder) with an internal byte-wide register file; the bus-side counterpart of our IIC master/SCL divider.

---
 rtl/iic_slave_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regs.sv
// IIC target with a byte-wide register file. SCL/SDA are oversampled on clk_i,
// glitch-filtered, and decoded by a single FSM; SDA is driven open-drain via sda_oe_o.

module iic_slave_regs_filt #(
  parameter int FILT_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_raw,
  output logic o_filt
);
  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_filt;

  // A new level is accepted only after FILT_CYC consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == 4'(FILT_CYC - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_filt = r_filt;
endmodule

module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter int         NUM_REGS = 16,
  parameter int         FILT_CYC = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_stb_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] host_addr_i,
  output logic [7:0] host_rdata_o,
  output logic       busy_o
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P,
    S_WDATA, S_ACK_W, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  logic [1:0] w_raw, w_filt;
  logic [1:0] r_filt_d;
  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic [AW-1:0] w_ptr_nxt;
  logic       w_unused;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_tx;
  logic          r_rw;
  logic [AW-1:0] r_ptr;
  logic          r_oe;
  logic          r_busy;
  logic          r_wr_stb;
  logic [7:0]    r_wr_addr, r_wr_data;
  logic [7:0]    r_host_rdata;
  logic [7:0]    r_regs [NUM_REGS];

  // Index 1 carries SCL, index 0 carries SDA.
  assign w_raw = {scl_i, sda_i};

  iic_slave_regs_filt #(.FILT_CYC(FILT_CYC)) u_filt [1:0] (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_raw  (w_raw),
    .o_filt (w_filt)
  );

  assign w_scl      = w_filt[1];
  assign w_sda      = w_filt[0];
  assign w_scl_rise = w_scl & ~r_filt_d[1];
  assign w_scl_fall = ~w_scl & r_filt_d[1];
  assign w_start    = w_scl & r_filt_d[1] & r_filt_d[0] & ~w_sda;
  assign w_stop     = w_scl & r_filt_d[1] & ~r_filt_d[0] & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_nxt  = r_ptr + 1'b1;
  assign w_unused   = &{1'b0, host_addr_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_filt_d  <= 2'b11;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_rw      <= 1'b0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_filt_d <= w_filt;
      r_wr_stb <= 1'b0;
      // Bus conditions override any bit-level activity.
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_state == S_WDATA && r_cnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_stb      <= 1'b1;
                r_wr_addr     <= 8'(r_ptr);
                r_wr_data     <= w_byte;
                r_ptr         <= w_ptr_nxt;
              end
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_cnt <= '0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_rw    <= r_shift[0];
                  r_oe    <= 1'b1;
                  r_state <= S_ACK_A;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else if (r_state == S_PTR) begin
                r_ptr   <= r_shift[AW-1:0];
                r_oe    <= 1'b1;
                r_state <= S_ACK_P;
              end else begin
                r_oe    <= 1'b1;
                r_state <= S_ACK_W;
              end
            end
          end
          S_ACK_A: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_tx    <= r_regs[r_ptr];
                r_oe    <= ~r_regs[r_ptr][7];
                r_state <= S_RDATA;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_PTR;
              end
            end
          end
          S_ACK_P, S_ACK_W: begin
            if (w_scl_fall) begin
              r_oe    <= 1'b0;
              r_state <= S_WDATA;
            end
          end
          S_RDATA: begin
            // r_cnt counts rising edges; the bit driven after a fall is 7-r_cnt.
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_oe    <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_RACK;
              end else begin
                r_oe <= ~r_tx[3'd7 - r_cnt[2:0]];
              end
            end
          end
          S_RACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_ptr   <= w_ptr_nxt;
                r_tx    <= r_regs[w_ptr_nxt];
                r_cnt   <= '0;
                r_state <= S_RDATA;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: r_oe <= 1'b0;
          default: begin
            r_oe    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_host_rdata <= '0;
    else       r_host_rdata <= r_regs[host_addr_i[AW-1:0]];
  end

  assign sda_oe_o     = r_oe;
  assign wr_stb_o     = r_wr_stb;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign host_rdata_o = r_host_rdata;
  assign busy_o       = r_busy;
endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench: bit-banged IIC master on an open-drain SDA model, checking
// ACKs, read data, write strobes and host-side register contents.

module tb_iic_slave_regs;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] wr_addr, wr_data, host_addr, host_rdata;

  int n_vec = 0, n_bad = 0;
  int n_stb = 0, n_oe = 0;
  logic [7:0] stb_a [64];
  logic [7:0] stb_d [64];

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  iic_slave_regs #(.DEV_ADDR(7'h21), .NUM_REGS(16), .FILT_CYC(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .sda_oe_o     (sda_oe),
    .wr_stb_o     (wr_stb),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .host_addr_i  (host_addr),
    .host_rdata_o (host_rdata),
    .busy_o       (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      if (n_stb < 64) begin
        stb_a[n_stb] = wr_addr;
        stb_d[n_stb] = wr_data;
      end
      n_stb++;
    end
    if (sda_oe) n_oe++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic smp);
    sda_m = b;    q();
    scl_m = 1'b1; q();
    smp = sda_i;  q();
    scl_m = 1'b0; q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(ack_bit, s);
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk) host_addr = a;
    @(negedge clk) chk(tag, host_rdata, exp);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         s0, o0;

    rst = 1'b1;
    host_addr = 8'd3;
    repeat (5) @(negedge clk);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_waddr", wr_addr, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // T1 single write
    s0 = n_stb;
    bus_start();
    chk("t1_busy_start", busy, 1);
    wr_byte(8'h42, ack); chk("t1_ack_addr", ack, 0);
    wr_byte(8'h03, ack); chk("t1_ack_ptr", ack, 0);
    wr_byte(8'hA5, ack); chk("t1_ack_data", ack, 0);
    bus_stop();
    chk("t1_busy_stop", busy, 0);
    chk("t1_nstb", n_stb - s0, 1);
    chk("t1_stb_addr", stb_a[s0], 8'h03);
    chk("t1_stb_data", stb_d[s0], 8'hA5);
    chk_reg("t1_reg3", 8'd3, 8'hA5);

    // T2 burst write wrapping past the last register
    s0 = n_stb;
    bus_start();
    wr_byte(8'h42, ack); chk("t2_ack_addr", ack, 0);
    wr_byte(8'h0E, ack);
    wr_byte(8'h11, ack);
    wr_byte(8'h22, ack);
    wr_byte(8'h33, ack); chk("t2_ack_last", ack, 0);
    bus_stop();
    chk("t2_nstb", n_stb - s0, 3);
    chk("t2_a0", stb_a[s0], 8'd14);
    chk("t2_a1", stb_a[s0 + 1], 8'd15);
    chk("t2_a2", stb_a[s0 + 2], 8'd0);
    chk("t2_d2", stb_d[s0 + 2], 8'h33);
    chk_reg("t2_reg14", 8'd14, 8'h11);
    chk_reg("t2_reg15", 8'd15, 8'h22);
    chk_reg("t2_reg0", 8'd0, 8'h33);
    chk_reg("t2_reg_mod", 8'd30, 8'h11);

    // T3 pointer write, repeated start, two-byte read
    s0 = n_stb;
    bus_start();
    wr_byte(8'h42, ack);
    wr_byte(8'h0E, ack);
    bus_start();
    wr_byte(8'h43, ack); chk("t3_ack_raddr", ack, 0);
    rd_byte(1'b0, d);    chk("t3_rd0", d, 8'h11);
    rd_byte(1'b1, d);    chk("t3_rd1", d, 8'h22);
    chk("t3_release", sda_oe, 0);
    bus_stop();
    chk("t3_nstb", n_stb - s0, 0);

    // T4 address mismatch
    s0 = n_stb; o0 = n_oe;
    bus_start();
    wr_byte(8'h44, ack); chk("t4_nack", ack, 1);
    wr_byte(8'h00, ack);
    wr_byte(8'hFF, ack);
    bus_stop();
    chk("t4_no_oe", n_oe - o0, 0);
    chk("t4_nstb", n_stb - s0, 0);
    chk_reg("t4_reg0", 8'd0, 8'h33);

    // T5 partial byte then STOP
    s0 = n_stb;
    bus_start();
    wr_byte(8'h42, ack);
    wr_byte(8'h05, ack);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
    bus_stop();
    chk("t5_busy", busy, 0);
    chk("t5_oe", sda_oe, 0);
    chk("t5_nstb", n_stb - s0, 0);
    chk_reg("t5_reg5", 8'd5, 8'h00);

    // T6a SCL glitch shorter than the filter must not count as a bit
    bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1;
    repeat (2) @(negedge clk);
    scl_m = 1'b0; q();
    wr_byte(8'h42, ack); chk("t6_glitch_ack", ack, 0);
    bus_stop();

    // T6b reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(d[0] ^ d[0] ? 1'b0 : 8'h42 >> i, s);
    sda_m = 1'b1;
    @(negedge clk);
    chk("t6_ack_drive", sda_oe, 1);
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_oe", sda_oe, 0);
    chk("t6_rst_busy", busy, 0);
    rst = 1'b0;
    s0 = n_stb; o0 = n_oe;
    send_bit(1'b1, s);
    wr_byte(8'h03, ack);
    wr_byte(8'h77, ack);
    bus_stop();
    chk("t6_post_oe", n_oe - o0, 0);
    chk("t6_post_nstb", n_stb - s0, 0);
    chk_reg("t6_reg3_cleared", 8'd3, 8'h00);

    // Recovery after reset: a fresh transaction works
    bus_start();
    wr_byte(8'h42, ack); chk("t6_rec_ack", ack, 0);
    wr_byte(8'h07, ack);
    wr_byte(8'h5A, ack);
    bus_stop();
    chk_reg("t6_rec_reg7", 8'd7, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
